// File: rtl/uart_rx_if.sv
// Serial-line and receive-strobe bundle between a UART receiver and the fabric side.
// The slave modport is the receiver; the master modport drives the line and consumes the strobes.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serial_in;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  framing_error;
  logic                  busy;

  modport master (
    output serial_in,
    input  rx_data, data_valid, parity_error, framing_error, busy
  );

  modport slave (
    input  serial_in,
    output rx_data, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Each bit is taken once at mid-bit; completed words are handed out with one-cycle strobes.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLOCKS_PER_BIT = 8,
  parameter int PARITY_EN      = 1,
  parameter int PARITY_ODD     = 0,
  parameter int SYNC_STAGES    = 3
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int NBITS = DATA_WIDTH + PARITY_EN + 1;
  localparam int TW    = $clog2(CLOCKS_PER_BIT);
  localparam int BW    = $clog2(NBITS);

  // START samples one tick early because the detect edge already consumed tick 0.
  localparam logic [TW-1:0] TICK_HALF = TW'(CLOCKS_PER_BIT / 2 - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]  sync_d;
  logic [TW-1:0]           tick_q;
  logic [BW-1:0]           bit_idx_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    par_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    data_valid_q;
  logic                    parity_error_q;
  logic                    framing_error_q;
  logic                    busy_q;
  logic                    rxs;
  logic                    tick_hit;
  logic                    parity_err_d;

  assign sync_d       = {sync_q[SYNC_STAGES-2:0], bus.serial_in};
  assign rxs          = sync_q[SYNC_STAGES-1];
  assign tick_hit     = (tick_q == TICK_LAST);
  assign parity_err_d = (PARITY_EN != 0) && ((^shreg_q ^ par_q) != 1'(PARITY_ODD));

  // Idle level is 1, so the synchronizer resets high to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT_HIGH;
      tick_q          <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      par_q           <= 1'b0;
      rx_data_q       <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        WAIT_HIGH: begin
          if (rxs) state_q <= IDLE;
        end
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            tick_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_q == TICK_HALF) begin
            tick_q <= '0;
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: begin
          tick_q <= tick_hit ? '0 : tick_q + 1'b1;
          if (tick_hit) begin
            // LSB arrives first, so shifting in from the top lands it at bit 0.
            shreg_q   <= {rxs, shreg_q[DATA_WIDTH-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_DATA) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          tick_q <= tick_hit ? '0 : tick_q + 1'b1;
          if (tick_hit) begin
            par_q     <= rxs;
            bit_idx_q <= bit_idx_q + 1'b1;
            state_q   <= STOP;
          end
        end
        STOP: begin
          tick_q <= tick_hit ? '0 : tick_q + 1'b1;
          if (tick_hit) begin
            busy_q <= 1'b0;
            if (rxs) begin
              rx_data_q      <= shreg_q;
              data_valid_q   <= 1'b1;
              parity_error_q <= parity_err_d;
              state_q        <= IDLE;
            end else begin
              // A low stop may be a break; wait for the line to recover before re-arming.
              framing_error_q <= 1'b1;
              state_q         <= WAIT_HIGH;
            end
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences and random frames
// checked against a frame-level timing/content model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW    = 8;
  localparam int C     = 8;
  localparam int PEN   = 1;
  localparam int PODD  = 0;
  localparam int S     = 3;
  localparam int NBITS = DW + PEN + 1;
  localparam int LAT   = S + C / 2 - 1 + NBITS * C;

  logic clk = 1'b0;
  logic reset;
  int   ecount = 0;
  int   checks = 0;
  int   errors = 0;
  int   stray_pe = 0;

  uart_rx_if #(.DATA_WIDTH(DW)) ifc ();

  uart_rx #(
    .DATA_WIDTH    (DW),
    .CLOCKS_PER_BIT(C),
    .PARITY_EN     (PEN),
    .PARITY_ODD    (PODD),
    .SYNC_STAGES   (S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int           edge_n;
    bit           fe;
    bit           dv;
    logic [DW-1:0] data;
    bit           pe;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (ifc.data_valid || ifc.framing_error)
      evq.push_back('{ecount, ifc.framing_error, ifc.data_valid, ifc.rx_data, ifc.parity_error});
    if (ifc.parity_error && !ifc.data_valid) stray_pe++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    ifc.serial_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Parity bit chosen from the ones count so that the frame is correct unless flip is set.
  task automatic send_frame(input logic [DW-1:0] d, input bit flip, input bit stopv,
                            input int stop_len, output int e0);
    bit pb;
    pb = bit'($countones(d) % 2) ^ bit'(PODD) ^ flip;
    e0 = ecount + 1;
    drive(1'b0, C);
    for (int i = 0; i < DW; i++) drive(d[i], C);
    drive(pb, C);
    drive(stopv, stop_len);
  endtask

  function automatic bit model_pe(input logic [DW-1:0] d, input bit flip);
    bit pb;
    pb = bit'($countones(d) % 2) ^ bit'(PODD) ^ flip;
    return ((($countones(d) + int'(pb)) % 2) != PODD);
  endfunction

  task automatic expect_one(input string nm, input bit efe, input logic [DW-1:0] ed,
                            input bit epe, input int eedge, input logic [DW-1:0] erx);
    chk({nm, " events"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      chk({nm, " fe"}, evq[0].fe, efe);
      chk({nm, " dv"}, evq[0].dv, !efe);
      chk({nm, " pe"}, evq[0].pe, efe ? 1'b0 : epe);
      chk({nm, " edge"}, evq[0].edge_n, eedge);
      if (!efe) chk({nm, " data"}, evq[0].data, ed);
    end
    chk({nm, " rx_data"}, ifc.rx_data, erx);
    chk({nm, " busy"}, ifc.busy, 0);
    evq.delete();
  endtask

  typedef struct {
    logic [DW-1:0] data;
    bit            flip;
    bit            stopv;
    bit            exp_fe;
    bit            exp_pe;
    logic [DW-1:0] exp_rx;
  } vec_t;

  initial begin
    vec_t          tbl[6];
    int            e0, e1, g0, bhi, bfirst;
    logic [DW-1:0] last_good;
    logic [DW-1:0] d;
    bit            flip, stopv, epe;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[2] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};

    reset = 1'b1;
    ifc.serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_data", ifc.rx_data, 0);
    chk("reset data_valid", ifc.data_valid, 0);
    chk("reset parity_error", ifc.parity_error, 0);
    chk("reset framing_error", ifc.framing_error, 0);
    chk("reset busy", ifc.busy, 0);
    reset = 1'b0;
    drive(1'b1, 2 * C);
    evq.delete();

    foreach (tbl[i]) begin
      send_frame(tbl[i].data, tbl[i].flip, tbl[i].stopv, C, e0);
      if (!tbl[i].stopv) begin
        bhi = 0;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          if (ifc.busy) bhi++;
        end
        chk($sformatf("vec%0d busy while low", i), bhi, 0);
      end
      drive(1'b1, 2 * C);
      expect_one($sformatf("vec%0d", i), tbl[i].exp_fe, tbl[i].data, tbl[i].exp_pe,
                 e0 + LAT, tbl[i].exp_rx);
    end
    last_good = 8'h01;

    // Short low glitch on an idle line must be rejected at the mid-start check.
    g0 = ecount + 1;
    ifc.serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ifc.serial_in = 1'b1;
    bhi = 0;
    bfirst = -1;
    for (int k = 0; k < 3 * C; k++) begin
      @(posedge clk);
      #1;
      if (ifc.busy) begin
        bhi++;
        if (bfirst < 0) bfirst = ecount;
      end
    end
    chk("glitch busy rise edge", bfirst, g0 + S);
    chk("glitch busy cycles", bhi, C / 2 - 1);
    chk("glitch events", evq.size(), 0);
    evq.delete();

    // Back-to-back frames, first stop bit truncated to half a bit.
    send_frame(8'h00, 1'b0, 1'b1, C / 2, e0);
    send_frame(8'hFF, 1'b0, 1'b1, C, e1);
    drive(1'b1, 2 * C);
    chk("b2b events", evq.size(), 2);
    if (evq.size() >= 2) begin
      chk("b2b first data", evq[0].data, 8'h00);
      chk("b2b first edge", evq[0].edge_n, e0 + LAT);
      chk("b2b second data", evq[1].data, 8'hFF);
      chk("b2b second edge", evq[1].edge_n, e1 + LAT);
      chk("b2b second dv", evq[1].dv, 1);
    end
    evq.delete();

    // Reset in the middle of data bit 3 aborts the frame silently.
    d = 8'h5A;
    ifc.serial_in = 1'b0;
    drive(1'b0, C);
    for (int i = 0; i < 3; i++) drive(d[i], C);
    drive(d[3], C / 2);
    reset = 1'b1;
    ifc.serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset busy", ifc.busy, 0);
    reset = 1'b0;
    drive(1'b1, 2 * C);
    chk("midreset events", evq.size(), 0);
    chk("midreset rx_data", ifc.rx_data, 0);
    evq.delete();
    send_frame(8'h5A, 1'b0, 1'b1, C, e0);
    drive(1'b1, 2 * C);
    expect_one("after reset", 1'b0, 8'h5A, 1'b0, e0 + LAT, 8'h5A);
    last_good = 8'h5A;

    for (int n = 0; n < 24; n++) begin
      d     = DW'($urandom);
      flip  = ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 4) != 0);
      epe   = stopv ? model_pe(d, flip) : 1'b0;
      send_frame(d, flip, stopv, C, e0);
      if (!stopv) drive(1'b0, $urandom_range(1, 3 * C));
      drive(1'b1, $urandom_range(2, 2 * C));
      if (stopv) last_good = d;
      expect_one($sformatf("rand%0d", n), !stopv, d, epe, e0 + LAT, last_good);
    end

    chk("stray parity_error", stray_pe, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Standalone UART receiver that recovers the serial frame produced by the team's UART transmitter. Frame format: idle-high line, 1 start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1). The block oversamples the line at CLOCKS_PER_BIT clocks per bit and takes each bit at mid-bit. It sits behind the board pin, or behind a tx serial_out in loopback benches, and hands completed bytes to fabric logic as a one-cycle valid strobe.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
CLOCKS_PER_BIT, 8, clk cycles per bit. Must be even and >= 4.
PARITY_EN, 1, 1 = parity bit present and checked; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity.
SYNC_STAGES, 3, number of flip-flops in the serial_in synchronizer. Must be >= 2.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
serial_in  input  1  asynchronous serial line; idle level is 1.
rx_data  output  DATA_WIDTH  last received data word; held until the next valid frame.
data_valid  output  1  one-cycle pulse; rx_data is new in that cycle.
parity_error  output  1  one-cycle pulse, coincident with data_valid, when the parity check fails.
framing_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
busy  output  1  high from start-bit detection until the stop sample.

Behaviour:
- Reset values: rx_data=0, data_valid=0, parity_error=0, framing_error=0, busy=0. All synchronizer flip-flops reset to 1. FSM goes to WAIT_HIGH.
- Reset mid-frame aborts the frame. No strobes are emitted.
- Synchronizer: serial_in passes through SYNC_STAGES flip-flops. The FSM sees only the last stage ("rxs").
- Bit counter: bit_idx runs 0..NBITS-1, where NBITS = DATA_WIDTH + PARITY_EN + 1. The stop bit is the last index.
- Tick counter: counts 0..CLOCKS_PER_BIT-1 and wraps.
- FSM states:
  - WAIT_HIGH: stay here until rxs=1, then go to IDLE. This prevents a stuck-low or break line from starting a frame.
  - IDLE: if rxs=0, go to START, clear the tick counter, busy=1.
  - START: when tick reaches CLOCKS_PER_BIT/2-1 (mid start bit), re-sample rxs. If rxs=1 it was a glitch: go to IDLE, busy=0, no strobes. If rxs=0, go to DATA with the tick counter cleared.
  - DATA: sample rxs every CLOCKS_PER_BIT clocks into shift register bit bit_idx (LSB first). After DATA_WIDTH samples, go to PARITY (PARITY_EN=1) or STOP.
  - PARITY: take one sample and store it as the parity bit. Go to STOP.
  - STOP: take one sample.
    - If rxs=1: load rx_data, pulse data_valid, and pulse parity_error if the parity check fails. Go to IDLE; busy=0 in that same cycle.
    - If rxs=0: pulse framing_error, leave rx_data unchanged, no data_valid. Go to WAIT_HIGH.
- Timing, with cycle 0 = first rising edge that captures serial_in=0 into sync stage 1:
  - Start is detected at edge SYNC_STAGES.
  - Sample k (k=0 is the start bit; the stop bit is k=NBITS) is taken at edge SYNC_STAGES + CLOCKS_PER_BIT/2 - 1 + k*CLOCKS_PER_BIT.
  - Strobes are registered at the stop-sample edge and are high for exactly one cycle after it.
  - Defaults: stop sample and strobes at edge 86.
- Back-to-back frames: after a good stop, IDLE can detect the next start bit from the next edge. This tolerates a stop bit truncated to half a bit.
- Parity check: error = (XOR(data) XOR parity_bit) != PARITY_ODD. When PARITY_EN=0, parity_error is never asserted.
- serial_in changes between sample points are ignored. There is no majority voting.
- data_valid and framing_error are never high in the same cycle.

Test Plan:
- Loopback with the team's UART tx at default parameters, sending i_data=8'hA5 → data_valid pulses once, rx_data=8'hA5, parity_error=0, framing_error=0, busy low afterwards.
- Directed frame 0x3C with the parity bit inverted → data_valid=1 and parity_error=1 in the same cycle, rx_data=8'h3C.
- Frame 0x81 with the stop bit driven 0 and the line held low 40 cycles → framing_error pulses once, no data_valid, rx_data keeps its previous value, no new start until the line returns to 1.
- 2-cycle low glitch on an idle line → busy rises then falls within CLOCKS_PER_BIT/2+SYNC_STAGES cycles, no strobes.
- Frames 0x00 then 0xFF back to back with the stop bit shortened to 4 clocks → two data_valid pulses with correct data.
- Reset asserted mid-frame (during data bit 3), then a full 0x5A frame → no strobe for the aborted frame, 0x5A received correctly.
